// File: rtl/lc3_mem_if.sv
// Request/response and memory-bus signals between the LC-3 control FSM, the
// memory-access sequencer and the SRAM/IO bus.
interface lc3_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();
  logic              Req;
  logic              Req_Write;
  logic [ADDR_W-1:0] Req_Addr;
  logic [DATA_W-1:0] Req_Wdata;
  logic              Busy;
  logic              Ack;
  logic              Timeout_Err;
  logic [DATA_W-1:0] Rdata;
  logic              Mem_CE_n;
  logic              Mem_WE_n;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Wdata;
  logic [DATA_W-1:0] Mem_Rdata;
  logic              Mem_Ready;

  // Sequencer side
  modport slave (
    input  Req, Req_Write, Req_Addr, Req_Wdata, Mem_Rdata, Mem_Ready,
    output Busy, Ack, Timeout_Err, Rdata, Mem_CE_n, Mem_WE_n, Mem_Addr, Mem_Wdata
  );

  // Control FSM plus memory side
  modport master (
    output Req, Req_Write, Req_Addr, Req_Wdata, Mem_Rdata, Mem_Ready,
    input  Busy, Ack, Timeout_Err, Rdata, Mem_CE_n, Mem_WE_n, Mem_Addr, Mem_Wdata
  );
endinterface

// File: rtl/lc3_mem_sequencer.sv
// One read or write per request, completed after a fixed wait or on Mem_Ready
// with a timeout; finishes with a 1-cycle Ack (plus Timeout_Err on timeout).
module lc3_mem_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int USE_READY   = 0,
  parameter int TIMEOUT     = 15
) (
  input  logic     Clk,
  input  logic     Reset,
  lc3_mem_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  // Wide enough for TIMEOUT, and for WAIT_CYCLES in fixed mode where TIMEOUT is unused
  localparam int CNT_MAX = (TIMEOUT > WAIT_CYCLES) ? TIMEOUT : WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] C_WAIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] C_TMO  = CNT_W'(TIMEOUT);

  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("lc3_mem_sequencer: WAIT_CYCLES must be >= 1");
    end
    if (USE_READY != 0 && TIMEOUT <= WAIT_CYCLES) begin : g_bad_tmo
      $error("lc3_mem_sequencer: TIMEOUT must exceed WAIT_CYCLES in ready mode");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_done;
  logic              w_tmo;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign w_accept  = bus.Req && (r_state != S_ACCESS);
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  // w_cnt_nxt is the number of ACCESS cycles completed at the coming edge
  always_comb begin
    w_done = 1'b0;
    w_tmo  = 1'b0;
    if (USE_READY != 0) begin
      w_done = (w_cnt_nxt >= C_WAIT) && bus.Mem_Ready;
      w_tmo  = !w_done && (w_cnt_nxt >= C_TMO);
    end else begin
      w_done = (w_cnt_nxt == C_WAIT);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_ACCESS: begin
          r_cnt <= w_cnt_nxt;
          if (w_done) begin
            r_state <= S_DONE;
            if (!r_write) r_rdata <= bus.Mem_Rdata;
          end else if (w_tmo) begin
            r_state <= S_ERR;
          end
        end
        default: begin
          // IDLE, DONE and ERR all accept a new request without a bubble
          if (w_accept) begin
            r_state <= S_ACCESS;
            r_cnt   <= '0;
            r_write <= bus.Req_Write;
            r_addr  <= bus.Req_Addr;
            r_wdata <= bus.Req_Wdata;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.Busy        = (r_state == S_ACCESS);
  assign bus.Ack         = (r_state == S_DONE) || (r_state == S_ERR);
  assign bus.Timeout_Err = (r_state == S_ERR);
  assign bus.Rdata       = r_rdata;
  assign bus.Mem_CE_n    = (r_state != S_ACCESS);
  assign bus.Mem_WE_n    = !((r_state == S_ACCESS) && r_write);
  assign bus.Mem_Addr    = r_addr;
  assign bus.Mem_Wdata   = r_wdata;

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// Directed bench for lc3_mem_sequencer: a fixed-latency and a ready-mode instance,
// with expected Ack results queued at request time and checked at Ack.
module tb_lc3_mem_sequencer;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [15:0] rd;
    logic        te;
  } exp_t;

  exp_t q_f[$];
  exp_t q_r[$];

  lc3_mem_if #(.DATA_W(16), .ADDR_W(16)) bf ();
  lc3_mem_if #(.DATA_W(16), .ADDR_W(16)) br ();

  lc3_mem_sequencer #(
    .DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(2), .USE_READY(0), .TIMEOUT(15)
  ) u_fix (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bf)
  );

  lc3_mem_sequencer #(
    .DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(2), .USE_READY(1), .TIMEOUT(15)
  ) u_rdy (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (br)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample(input bit sel, output logic busy, output logic ack, output logic te,
                        output logic ce_n, output logic we_n, output logic [15:0] rd,
                        output logic [15:0] ma, output logic [15:0] mw);
    if (sel) begin
      busy = br.Busy; ack = br.Ack; te = br.Timeout_Err; ce_n = br.Mem_CE_n;
      we_n = br.Mem_WE_n; rd = br.Rdata; ma = br.Mem_Addr; mw = br.Mem_Wdata;
    end else begin
      busy = bf.Busy; ack = bf.Ack; te = bf.Timeout_Err; ce_n = bf.Mem_CE_n;
      we_n = bf.Mem_WE_n; rd = bf.Rdata; ma = bf.Mem_Addr; mw = bf.Mem_Wdata;
    end
  endtask

  task automatic chk_reset(input bit sel, input string tag);
    logic busy, ack, te, ce_n, we_n;
    logic [15:0] rd, ma, mw;
    sample(sel, busy, ack, te, ce_n, we_n, rd, ma, mw);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_ack"},  32'(ack),  32'(0));
    chk({tag, "_terr"}, 32'(te),   32'(0));
    chk({tag, "_ce_n"}, 32'(ce_n), 32'(1));
    chk({tag, "_we_n"}, 32'(we_n), 32'(1));
    chk({tag, "_rdata"}, 32'(rd),  32'(0));
    chk({tag, "_addr"}, 32'(ma),   32'(0));
    chk({tag, "_wdata"}, 32'(mw),  32'(0));
  endtask

  task automatic drive_req(input bit sel, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata);
    if (sel) begin
      br.Req = 1'b1; br.Req_Write = wr; br.Req_Addr = addr; br.Req_Wdata = wdata;
    end else begin
      bf.Req = 1'b1; bf.Req_Write = wr; bf.Req_Addr = addr; bf.Req_Wdata = wdata;
    end
  endtask

  // Issue one request in the current cycle and follow it until Ack (or a cycle bound).
  // lat is the expected number of cycles from the request cycle to the Ack cycle.
  task automatic run_access(input string tag, input bit sel, input bit wr,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp_rd, input bit exp_te,
                            input int lat, input int rdy_at);
    logic busy, ack, te, ce_n, we_n;
    logic [15:0] rd, ma, mw;
    exp_t e;
    int n = 0;
    drive_req(sel, wr, addr, wdata);
    if (sel) q_r.push_back({exp_rd, exp_te});
    else     q_f.push_back({exp_rd, exp_te});
    ack = 1'b0;
    while (!ack && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        if (sel) br.Req = 1'b0;
        else     bf.Req = 1'b0;
      end
      if (sel && n == rdy_at) br.Mem_Ready = 1'b1;
      sample(sel, busy, ack, te, ce_n, we_n, rd, ma, mw);
      if (!ack) begin
        chk({tag, "_busy"}, 32'(busy), 32'(1));
        chk({tag, "_ce_n"}, 32'(ce_n), 32'(0));
        chk({tag, "_we_n"}, 32'(we_n), 32'(!wr));
        chk({tag, "_addr"}, 32'(ma),   32'(addr));
        if (wr) chk({tag, "_wdata"}, 32'(mw), 32'(wdata));
      end
    end
    chk({tag, "_ack_seen"}, 32'(ack), 32'(1));
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    if (ack) begin
      if (sel) e = q_r.pop_front();
      else     e = q_f.pop_front();
      chk({tag, "_rdata"},    32'(rd),   32'(e.rd));
      chk({tag, "_terr"},     32'(te),   32'(e.te));
      chk({tag, "_ack_busy"}, 32'(busy), 32'(0));
      chk({tag, "_ack_ce_n"}, 32'(ce_n), 32'(1));
      chk({tag, "_ack_we_n"}, 32'(we_n), 32'(1));
    end
  endtask

  initial begin
    Reset = 1'b1;
    bf.Req = 1'b0; bf.Req_Write = 1'b0; bf.Req_Addr = '0; bf.Req_Wdata = '0;
    bf.Mem_Rdata = '0; bf.Mem_Ready = 1'b0;
    br.Req = 1'b0; br.Req_Write = 1'b0; br.Req_Addr = '0; br.Req_Wdata = '0;
    br.Mem_Rdata = '0; br.Mem_Ready = 1'b0;
    tick();
    tick();
    chk_reset(0, "rst_fix");
    chk_reset(1, "rst_rdy");
    Reset = 1'b0;
    tick();

    // Fixed-mode read, then a back-to-back read requested in the Ack cycle
    bf.Mem_Rdata = 16'h1234;
    run_access("t1_read", 0, 0, 16'h3000, 16'h0000, 16'h1234, 0, 3, 0);
    bf.Mem_Rdata = 16'h5678;
    run_access("t3_b2b", 0, 0, 16'h3002, 16'h0000, 16'h5678, 0, 3, 0);
    tick();

    // Fixed-mode write leaves Rdata untouched even with new data on the bus
    bf.Mem_Rdata = 16'hDEAD;
    run_access("t2_write", 0, 1, 16'h3001, 16'hBEEF, 16'h5678, 0, 3, 0);
    tick();
    chk("t2_idle_ack", 32'(bf.Ack), 32'(0));
    chk("t2_idle_rdata", 32'(bf.Rdata), 32'(16'h5678));

    // Ready mode: Mem_Ready raised in the 5th ACCESS cycle
    br.Mem_Rdata = 16'hA5A5;
    run_access("t4_ready", 1, 0, 16'h3100, 16'h0000, 16'hA5A5, 0, 6, 5);
    br.Mem_Ready = 1'b0;
    tick();

    // Ready mode: Mem_Ready already high still waits the minimum WAIT_CYCLES
    br.Mem_Ready = 1'b1;
    br.Mem_Rdata = 16'h0F0F;
    run_access("t4_early", 1, 0, 16'h3104, 16'h0000, 16'h0F0F, 0, 3, 0);
    br.Mem_Ready = 1'b0;
    tick();

    // Ready mode timeout: Ack with Timeout_Err on t+16, Rdata unchanged
    br.Mem_Rdata = 16'h1111;
    run_access("t5_tmo", 1, 0, 16'h3108, 16'h0000, 16'h0F0F, 1, 16, 0);
    tick();
    chk("t5_after_ce_n", 32'(br.Mem_CE_n), 32'(1));
    chk("t5_after_ack",  32'(br.Ack), 32'(0));
    chk("t5_after_terr", 32'(br.Timeout_Err), 32'(0));
    chk("t5_after_rdata", 32'(br.Rdata), 32'(16'h0F0F));

    // Reset in the 2nd ACCESS cycle; a Req during Busy beforehand is ignored
    bf.Mem_Rdata = 16'h9999;
    drive_req(0, 0, 16'h4000, 16'h0000);
    tick();
    drive_req(0, 1, 16'h5555, 16'h7777);
    chk("t6_acc1_busy", 32'(bf.Busy), 32'(1));
    tick();
    bf.Req = 1'b0;
    chk("t6_acc2_busy", 32'(bf.Busy), 32'(1));
    chk("t6_acc2_addr", 32'(bf.Mem_Addr), 32'(16'h4000));
    chk("t6_acc2_we_n", 32'(bf.Mem_WE_n), 32'(1));
    Reset = 1'b1;
    tick();
    chk_reset(0, "t6_rst");
    Reset = 1'b0;
    tick();
    chk("t6_post_busy", 32'(bf.Busy), 32'(0));
    chk("t6_post_ack",  32'(bf.Ack), 32'(0));
    chk("t6_post_ce_n", 32'(bf.Mem_CE_n), 32'(1));
    run_access("t6_recover", 0, 0, 16'h3000, 16'h0000, 16'h9999, 0, 3, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
